// File: rtl/logic_unit_pipe.sv
// Handshaked bitwise-logic unit: one registered compute stage feeding
// a small result FIFO with zero/parity flags and tag passthrough.
module logic_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_zero,
    output logic             out_parity,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + TAGW + 2;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_result;
    logic [TAGW-1:0]  s1_tag;
    logic             s1_zero;
    logic             s1_parity;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      fifo_count;
    logic [AW+1:0]    occ;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] calc;
    logic [EW-1:0]    head;

    always_comb begin
        calc = '0;
        unique case (in_op)
            OP_AND:  calc = in_a & in_b;
            OP_OR:   calc = in_a | in_b;
            OP_XOR:  calc = in_a ^ in_b;
            OP_NOR:  calc = ~(in_a | in_b);
            OP_NAND: calc = ~(in_a & in_b);
            OP_XNOR: calc = ~(in_a ^ in_b);
            OP_NOTA: calc = ~in_a;
            OP_PASS: calc = in_a;
            default: calc = '0;
        endcase
    end

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                     && (wr_ptr[AW] != rd_ptr[AW]);

    assign occ = {1'b0, fifo_count} + {{(AW+1){1'b0}}, s1_valid};

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && (!fifo_full || pop);

    // S1 acts as one extra slot, so total capacity is DEPTH + 1
    assign in_ready = (occ <= (AW+2)'(DEPTH)) || pop;
    assign accept   = in_valid && in_ready;

    assign busy = s1_valid || !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_result <= '0;
            s1_tag    <= '0;
            s1_zero   <= 1'b0;
            s1_parity <= 1'b0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_result <= calc;
            s1_tag    <= in_tag;
            s1_zero   <= ~|calc;
            s1_parity <= ^calc;
        end else if (push) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {s1_result, s1_tag, s1_zero, s1_parity};
    end

    assign head = mem[rd_ptr[AW-1:0]];

    assign out_result = out_valid ? head[EW-1 -: WIDTH] : '0;
    assign out_tag    = out_valid ? head[TAGW+1 -: TAGW] : '0;
    assign out_zero   = out_valid ? head[1] : 1'b0;
    assign out_parity = out_valid ? head[0] : 1'b0;

endmodule
